// File: rtl/lcd_text_ctrl.sv
// HD44780 8-bit write-only text controller: panel init, then a ROWS x COLS frame
// read from an external synchronous ROM, rewritten only on a message request.
module lcd_text_ctrl #(
  parameter int unsigned NUM_MSG    = 4,
  parameter int unsigned ROWS       = 2,
  parameter int unsigned COLS       = 16,
  parameter int unsigned EN_CYCLES  = 12,
  parameter int unsigned GAP_CYCLES = 2500,
  parameter int unsigned CLR_CYCLES = 100000,
  localparam int unsigned MSG_W     = $clog2(NUM_MSG),
  localparam int unsigned ADDR_W    = $clog2(NUM_MSG * ROWS * COLS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [MSG_W-1:0]  msg_sel,
  input  logic              msg_req,
  output logic              msg_ack,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic              rs,
  output logic              rw,
  output logic              en,
  output logic [7:0]        dat,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned CNT_W = $clog2(CLR_CYCLES + 1);
  localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_INIT   = 3'd1;
  localparam logic [2:0] S_ROWADR = 3'd2;
  localparam logic [2:0] S_CHARS  = 3'd3;
  localparam logic [2:0] S_SHOW   = 3'd4;

  localparam logic [1:0] PH_NONE  = 2'd0;
  localparam logic [1:0] PH_SETUP = 2'd1;
  localparam logic [1:0] PH_EN    = 2'd2;
  localparam logic [1:0] PH_WAIT  = 2'd3;

  logic [2:0]        state_q, state_d;
  logic [1:0]        phase_q, phase_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic              row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [MSG_W-1:0]  cur_msg_q, cur_msg_d;
  logic [MSG_W-1:0]  req_sel_q, req_sel_d;
  logic              pending_q, pending_d;
  logic              rs_q, rs_d;
  logic              en_q, en_d;
  logic [7:0]        dat_q, dat_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              msg_ack_q, msg_ack_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;

  logic              wait_done;
  logic              launch_cmd;
  logic              launch_char;
  logic              take_msg;
  logic [7:0]        cmd;
  logic [31:0]       sel_ext;
  logic [MSG_W-1:0]  sel_clamped;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    row_d        = row_q;
    col_d        = col_q;
    cur_msg_d    = cur_msg_q;
    req_sel_d    = req_sel_q;
    pending_d    = pending_q;
    rs_d         = rs_q;
    dat_d        = dat_q;
    frame_done_d = 1'b0;
    msg_ack_d    = 1'b0;
    wait_done    = 1'b0;
    launch_cmd   = 1'b0;
    launch_char  = 1'b0;
    take_msg     = 1'b0;
    cmd          = '0;

    sel_ext     = 32'(msg_sel);
    sel_clamped = (sel_ext > NUM_MSG - 1) ? MSG_W'(NUM_MSG - 1) : msg_sel;

    // Transaction timing: one setup cycle, EN_CYCLES strobe, then the settle wait.
    case (phase_q)
      PH_SETUP: begin
        phase_d = PH_EN;
        cnt_d   = CNT_W'(EN_CYCLES - 1);
      end
      PH_EN: begin
        if (cnt_q == '0) begin
          phase_d = PH_WAIT;
          cnt_d   = (!rs_q && dat_q == 8'h01) ? CNT_W'(CLR_CYCLES - 1)
                                              : CNT_W'(GAP_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      PH_WAIT: begin
        if (cnt_q == '0) wait_done = 1'b1;
        else             cnt_d = cnt_q - 1'b1;
      end
      default: ;
    endcase

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d    = S_INIT;
          idx_d      = '0;
          launch_cmd = 1'b1;
          cmd        = 8'h38;
        end
      end
      S_INIT: begin
        if (wait_done) begin
          if (idx_q == 2'd3) begin
            state_d    = S_ROWADR;
            take_msg   = 1'b1;
            launch_cmd = 1'b1;
            cmd        = 8'h80;
          end else begin
            idx_d      = idx_q + 1'b1;
            launch_cmd = 1'b1;
            case (idx_q)
              2'd0:    cmd = 8'h06;
              2'd1:    cmd = 8'h0C;
              default: cmd = 8'h01;
            endcase
          end
        end
      end
      S_ROWADR: begin
        if (wait_done) begin
          state_d     = S_CHARS;
          launch_char = 1'b1;
        end
      end
      S_CHARS: begin
        // col/row already point at the next character, so col==0 means the row is done
        if (wait_done) begin
          if (col_q != '0) begin
            launch_char = 1'b1;
          end else if (row_q) begin
            state_d    = S_ROWADR;
            launch_cmd = 1'b1;
            cmd        = 8'hC0;
          end else begin
            state_d      = S_SHOW;
            phase_d      = PH_NONE;
            frame_done_d = 1'b1;
          end
        end
      end
      S_SHOW: begin
        if (pending_q) begin
          state_d    = S_ROWADR;
          take_msg   = 1'b1;
          launch_cmd = 1'b1;
          cmd        = 8'h80;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (launch_cmd) begin
      phase_d = PH_SETUP;
      rs_d    = 1'b0;
      dat_d   = cmd;
    end

    // Pointer advances at launch so the ROM has the whole transaction to respond.
    if (launch_char) begin
      phase_d = PH_SETUP;
      rs_d    = 1'b1;
      dat_d   = rom_data;
      if (col_q == COL_W'(COLS - 1)) begin
        col_d = '0;
        row_d = (32'(row_q) == ROWS - 1) ? 1'b0 : ~row_q;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    if (take_msg && pending_q) begin
      cur_msg_d = req_sel_q;
      pending_d = 1'b0;
    end

    // A request on the consuming cycle wins over the clear above.
    if (msg_req && state_q != S_IDLE) begin
      req_sel_d = sel_clamped;
      pending_d = 1'b1;
      msg_ack_d = 1'b1;
    end

    en_d       = (phase_d == PH_EN);
    busy_d     = (state_d != S_IDLE) && (state_d != S_SHOW);
    rom_addr_d = ADDR_W'(32'(cur_msg_d) * ROWS * COLS + 32'(row_d) * COLS + 32'(col_d));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      phase_q      <= PH_NONE;
      cnt_q        <= '0;
      idx_q        <= '0;
      row_q        <= 1'b0;
      col_q        <= '0;
      cur_msg_q    <= '0;
      req_sel_q    <= '0;
      pending_q    <= 1'b0;
      rs_q         <= 1'b0;
      en_q         <= 1'b0;
      dat_q        <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      msg_ack_q    <= 1'b0;
      rom_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      row_q        <= row_d;
      col_q        <= col_d;
      cur_msg_q    <= cur_msg_d;
      req_sel_q    <= req_sel_d;
      pending_q    <= pending_d;
      rs_q         <= rs_d;
      en_q         <= en_d;
      dat_q        <= dat_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      msg_ack_q    <= msg_ack_d;
      rom_addr_q   <= rom_addr_d;
    end
  end

  assign rs         = rs_q;
  assign rw         = 1'b0;
  assign en         = en_q;
  assign dat        = dat_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign msg_ack    = msg_ack_q;
  assign rom_addr   = rom_addr_q;

endmodule
